rv32_uart_tx: RTL and testbench
===============================

# rv32_uart_tx

Memory-mapped UART transmitter that sits as a responder on the picorv32 native memory bus, selected by the address arbiter alongside program BRAM and the seven-segment register. Software writes bytes into a transmit FIFO; a baud-rate state machine shifts each byte out serially as 8N1, or 8E1 when parity is compiled in. A status register exposes busy, full, empty and FIFO occupancy for polling.

## Interface
- `CLKS_PER_BIT`, default 217: clk cycles per serial bit (25 MHz / 115200); legal range is 2 or more.
- `FIFO_DEPTH_LOG2`, default 4: the FIFO holds 2^`FIFO_DEPTH_LOG2` bytes; legal range is 1 to 8.
- `clk`  in  1: system clock, same clock as the CPU.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rv32_valid`  in  1: request from the arbiter; held high until `rv32_ready` is seen.
- `rv32_ready`  out  1: acknowledge; a registered single-cycle pulse.
- `rv32_addr`  in  32: only bit 2 is decoded (0 = DATA at offset 0x0, 1 = STATUS at offset 0x4).
- `rv32_wdata`  in  32: write data; DATA uses bits [7:0].
- `rv32_wstrb`  in  4: all zero means read; any non-zero value means write.
- `rv32_rdata`  out  32: read data; zero in every cycle where `rv32_ready` is low, so it can be OR-merged onto the bus.
- `txd`  out  1: serial output; idles high.

## Operation
- Reset values:
  - `rv32_ready` = 0, `rv32_rdata` = 0, `txd` = 1.
  - FIFO is empty and the FSM is in IDLE.
- Bus accept condition: `rv32_valid` & !`rv32_ready`, and the access is not a DATA write while the FIFO is full.
- Acknowledge: when the accept condition holds, `rv32_ready` is 1 in the next cycle, for exactly one cycle.
- DATA write with `rv32_wstrb`[0] = 1: pushes `rv32_wdata`[7:0] on the acknowledge edge.
- DATA write with `rv32_wstrb`[0] = 0: acknowledged; no push.
- DATA write while the FIFO is full: `rv32_ready` is withheld, stalling the CPU, until a slot frees.
- STATUS write: acknowledged and ignored.
- DATA read: returns 0.
- STATUS read returns:
  - bit0 busy (FSM not in IDLE)
  - bit1 full
  - bit2 empty
  - bits [8 +: `FIFO_DEPTH_LOG2`+1] FIFO count
  - all other bits 0
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: `txd` = 0.
  - DATA: drives 8 bits LSB first; a 3-bit index counts 0 to 7.
  - STOP: `txd` = 1.
  - Every state except IDLE lasts exactly `CLKS_PER_BIT` cycles, using a down-counter of width $clog2(`CLKS_PER_BIT`).
  - At the end of STOP, go directly to START (pop) if the FIFO is non-empty; otherwise go to IDLE. There is no idle gap between queued frames.
- A simultaneous push and pop on the same edge is legal: both occur and the count is unchanged.
- Full is count == 2^`FIFO_DEPTH_LOG2`; empty is count == 0. The pointers wrap modulo the depth.
- `txd` is driven from a register, so it never glitches.
- Reset asserted mid-frame: `txd` goes to 1 immediately (asynchronous), the FIFO is flushed, and any pending stalled write is dropped.

## Timing
- Request to acknowledge latency is 1 cycle when not stalled.
- Stall release: `rv32_ready` asserts, at the earliest, in the cycle after the pop edge that freed a slot.
- Write to an idle transmitter: `txd` falls in the cycle immediately after the acknowledge cycle.
- Frame length: 10×`CLKS_PER_BIT` cycles without parity; 11×`CLKS_PER_BIT` cycles with parity.
- The STATUS value returned is the registered state sampled on the accept edge.

## Configuration
- Macro: `RV32_UART_TX_PARITY_EN`.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - `txd` = even parity, the XOR of the 8 data bits.
  - Frame format is 8E1.
- Undefined:
  - The PARITY state and its logic are absent.
  - Frame format is 8N1.

## Structure
- Package `rv32_uart_tx_pkg` holds:
  - FSM state encoding
  - register offsets (DATA 0x0, STATUS 0x4)
  - STATUS bit positions and the count field offset (8)
- Sub-module `sync_fifo`: parameterized width and depth-log2, single clock, with push, pop, dout, full, empty and count. It is reusable for a future UART receiver.

## Test plan
Bench uses `CLKS_PER_BIT`=4 and `FIFO_DEPTH_LOG2`=2.
- Reset, then read STATUS: `txd`=1 and `rv32_rdata`=0x0000_0004 in the ready cycle; `rv32_rdata`=0 in all other cycles.
- Write 0x55 to DATA (`wstrb`=4'b0001): ready 1 cycle after valid. `txd` then shows start 0, bits 1,0,1,0,1,0,1,0, then stop 1, each held 4 cycles: 40 cycles total, 44 with parity (parity bit 0).
- Six back-to-back DATA writes: writes 1–5 ack without a stall (byte 1 is popped immediately, then 4 bytes are queued). Write 6 stalls until byte 2 pops at the end of frame 1, roughly 40 cycles later. The six frames are transmitted contiguously with no idle gap.
- STATUS read during frame 1 with 3 bytes queued returns 0x0000_0301 (busy, count=3).
- DATA write with `wstrb`=0 and a STATUS write of 0xFFFF_FFFF: both ack in 1 cycle, `txd` stays 1, and STATUS is unchanged at 0x0000_0004.
- Assert `reset_n` mid-DATA state: `txd`=1 within the same cycle (asynchronous); after release, STATUS = 0x0000_0004 and no frame is resumed.

Source files
------------

// File: rtl/rv32_uart_tx_pkg.sv
// ============================================================================
// Module   : rv32_uart_tx_pkg
// Brief    : Shared FSM encoding, register map and STATUS layout for the UART TX.
// Options  : RV32_UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef RV32_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [31:0] c_OFFSET_DATA   = 32'h0000_0000;
  localparam logic [31:0] c_OFFSET_STATUS = 32'h0000_0004;

  localparam int unsigned c_STATUS_BUSY      = 0;
  localparam int unsigned c_STATUS_FULL      = 1;
  localparam int unsigned c_STATUS_EMPTY     = 2;
  localparam int unsigned c_STATUS_COUNT_LSB = 8;

  // Count is passed zero-extended to the widest legal FIFO (depth-log2 of 8).
  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic [8:0] count);
    logic [31:0] v_word;
    v_word                               = '0;
    v_word[c_STATUS_BUSY]                = busy;
    v_word[c_STATUS_FULL]                = full;
    v_word[c_STATUS_EMPTY]               = empty;
    v_word[c_STATUS_COUNT_LSB +: 9]      = count;
    return v_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_uart_tx_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with occupancy count; pointers wrap modulo depth.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full      = (r_count == c_FULL_COUNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32_uart_tx.sv
// ============================================================================
// Module   : rv32_uart_tx
// Brief    : picorv32-bus UART transmitter: DATA/STATUS registers, TX FIFO, 8N1.
// Options  : define RV32_UART_TX_PARITY_EN for 8E1 framing (even parity bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_uart_tx
  import rv32_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 217,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rv32_valid,
  output logic        rv32_ready,
  input  logic [31:0] rv32_addr,
  input  logic [31:0] rv32_wdata,
  input  logic [3:0]  rv32_wstrb,
  output logic [31:0] rv32_rdata,
  output logic        txd
);

  localparam int                c_CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_RELOAD = c_CNT_W'(CLKS_PER_BIT - 1);

  logic                     r_ready;
  logic [31:0]              r_rdata;
  logic                     r_txd;
  tx_state_t                r_state;
  logic [c_CNT_W-1:0]       r_cnt;
  logic [2:0]               r_bit_idx;
  logic [7:0]               r_shift;

  logic [7:0]               w_fifo_dout;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] w_fifo_count;
  logic [31:0]              w_addr_off;
  logic                     w_is_data;
  logic                     w_is_status;
  logic                     w_is_write;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_bit_end;
  logic [31:0]              w_status;
  logic                     w_unused;

  assign rv32_ready = r_ready;
  assign rv32_rdata = r_rdata;
  assign txd        = r_txd;

  assign w_addr_off  = {29'd0, rv32_addr[2], 2'd0};
  assign w_is_data   = (w_addr_off == c_OFFSET_DATA);
  assign w_is_status = (w_addr_off == c_OFFSET_STATUS);
  assign w_is_write  = |rv32_wstrb;
  assign w_unused    = ^{rv32_addr[31:3], rv32_addr[1:0], rv32_wdata[31:8]};

  // A DATA write into a full FIFO is held off until a pop frees a slot.
  assign w_accept = rv32_valid && !r_ready && !(w_is_write && w_is_data && w_fifo_full);
  assign w_push   = w_accept && w_is_write && w_is_data && rv32_wstrb[0];

  assign w_bit_end = (r_cnt == '0);
  assign w_pop     = !w_fifo_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  assign w_status = pack_status(r_state != ST_IDLE, w_fifo_full, w_fifo_empty,
                                9'(w_fifo_count));

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .din     (rv32_wdata[7:0]),
    .pop     (w_pop),
    .dout    (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && !w_is_write && w_is_status) ? w_status : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_txd     <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (w_pop) begin
      // Covers both IDLE and back-to-back frames leaving STOP.
      r_shift <= w_fifo_dout;
      r_state <= ST_START;
      r_cnt   <= c_CNT_RELOAD;
      r_txd   <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_cnt <= w_bit_end ? c_CNT_RELOAD : r_cnt - 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef RV32_UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_txd   <= ^r_shift;
`else
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[r_bit_idx + 3'd1];
            end
          end
        end
`ifdef RV32_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32_uart_tx.sv
// ============================================================================
// Module   : tb_rv32_uart_tx
// Brief    : Self-checking bench for rv32_uart_tx against a bit-stream model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_uart_tx;

  localparam int c_CPB   = 4;
  localparam int c_DL2   = 2;
  localparam int c_DEPTH = 4;
`ifdef RV32_UART_TX_PARITY_EN
  localparam int          c_NSYM = 11;
  localparam logic [10:0] c_F55  = 11'b1_0_01010101_0;
`else
  localparam int          c_NSYM = 10;
  localparam logic [10:0] c_F55  = 11'b1_1_01010101_0;
`endif

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic        rv32_valid = 1'b0;
  logic [31:0] rv32_addr  = '0;
  logic [31:0] rv32_wdata = '0;
  logic [3:0]  rv32_wstrb = '0;
  logic        rv32_ready;
  logic [31:0] rv32_rdata;
  logic        txd;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_uart_tx #(
    .CLKS_PER_BIT    (c_CPB),
    .FIFO_DEPTH_LOG2 (c_DL2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rv32_valid (rv32_valid),
    .rv32_ready (rv32_ready),
    .rv32_addr  (rv32_addr),
    .rv32_wdata (rv32_wdata),
    .rv32_wstrb (rv32_wstrb),
    .rv32_rdata (rv32_rdata),
    .txd        (txd)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte queue plus the queue of line levels still to be shown, one per cycle.
  byte unsigned m_q[$];
  bit           m_line[$];
  bit           m_cur   = 1'b1;
  bit           m_busy  = 1'b0;
  bit           m_ready = 1'b0;
  logic [31:0]  m_rdata = '0;

  initial forever begin : model
    bit           full_pre, wr, is_status, accept, v;
    logic [31:0]  st;
    byte unsigned b;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_q.delete();
      m_line.delete();
      m_cur   = 1'b1;
      m_busy  = 1'b0;
      m_ready = 1'b0;
      m_rdata = '0;
    end else begin
      full_pre  = (m_q.size() == c_DEPTH);
      wr        = (rv32_wstrb != 4'd0);
      is_status = rv32_addr[2];
      accept    = rv32_valid && !m_ready && !(wr && !is_status && full_pre);
      st = m_q.size() * 256 + (m_q.size() == 0 ? 4 : 0) + (full_pre ? 2 : 0) + (m_busy ? 1 : 0);
      if (m_line.size() == 0 && m_q.size() != 0) begin
        b = m_q.pop_front();
        for (int s = 0; s < c_NSYM; s++) begin
          if (s == 0) v = 1'b0;
          else if (s <= 8) v = b[s-1];
          else if (s == 9 && c_NSYM == 11) v = ^b;
          else v = 1'b1;
          for (int k = 0; k < c_CPB; k++) m_line.push_back(v);
        end
      end
      if (m_line.size() != 0) begin
        m_cur  = m_line.pop_front();
        m_busy = 1'b1;
      end else begin
        m_cur  = 1'b1;
        m_busy = 1'b0;
      end
      if (accept && wr && !is_status && rv32_wstrb[0]) m_q.push_back(rv32_wdata[7:0]);
      m_rdata = (accept && !wr && is_status) ? st : 32'd0;
      m_ready = accept;
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (reset_n) begin
      check("ready", {31'd0, rv32_ready}, {31'd0, m_ready});
      check("rdata", rv32_rdata, m_rdata);
      check("txd", {31'd0, txd}, {31'd0, m_cur});
    end
  end

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    rv32_valid = 1'b1;
    rv32_addr  = addr;
    rv32_wdata = wdata;
    rv32_wstrb = wstrb;
    lat        = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv32_ready && lat < 400);
    if (!rv32_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_timeout: ready=0 after %0d cycles, required an acknowledge", lat);
    end
    rd         = rv32_rdata;
    rv32_valid = 1'b0;
    rv32_wstrb = 4'd0;
  endtask

  initial begin : stim
    logic [31:0] rd;
    logic [10:0] f55;
    int          lat;
    f55 = c_F55;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_ready", {31'd0, rv32_ready}, 32'd0);
    check("rst_rdata", rv32_rdata, 32'd0);
    reset_n = 1'b1;

    bus(32'h4, 32'h0, 4'h0, rd, lat);
    check("status_after_reset", rd, 32'h0000_0004);
    check("status_lat", lat, 32'd1);

    bus(32'h0, 32'h55, 4'h1, rd, lat);
    check("w55_lat", lat, 32'd1);
    for (int i = 0; i < c_NSYM * c_CPB; i++) begin
      @(negedge clk);
      check("frame55_bit", {31'd0, txd}, {31'd0, f55[i / c_CPB]});
    end
    bus(32'h4, 32'h0, 4'h0, rd, lat);
    check("status_after_frame", rd, 32'h0000_0004);

    for (int k = 0; k < 4; k++) begin
      bus(32'h0, $urandom, 4'h1, rd, lat);
      check("burst_lat", lat, 32'd1);
    end
    bus(32'h4, 32'h0, 4'h0, rd, lat);
    check("status_frame1", rd, 32'h0000_0301);
    bus(32'h0, $urandom, 4'h1, rd, lat);
    check("w5_lat", lat, 32'd1);
    bus(32'h0, $urandom, 4'h1, rd, lat);
    check("w6_stalled", {31'd0, lat > 20}, 32'd1);
    repeat (6 * c_NSYM * c_CPB + 20) @(negedge clk);
    bus(32'h4, 32'h0, 4'h0, rd, lat);
    check("status_drained", rd, 32'h0000_0004);

    bus(32'h0, 32'hA5, 4'h0, rd, lat);
    check("nostrb_lat", lat, 32'd1);
    bus(32'h4, 32'hFFFF_FFFF, 4'hF, rd, lat);
    check("status_wr_lat", lat, 32'd1);
    repeat (8) @(negedge clk);
    check("txd_idle", {31'd0, txd}, 32'd1);
    bus(32'h4, 32'h0, 4'h0, rd, lat);
    check("status_unchanged", rd, 32'h0000_0004);

    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 9) < 7) begin
        bus($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h1, rd, lat);
      end else begin
        bus($urandom, $urandom, 4'h0, rd, lat);
      end
    end
    repeat ((c_DEPTH + 2) * c_NSYM * c_CPB) @(negedge clk);

    bus(32'h0, 32'h3C, 4'h1, rd, lat);
    repeat (c_CPB + 2) @(negedge clk);
    check("pre_reset_txd", {31'd0, txd}, 32'd0);
    #2 reset_n = 1'b0;
    #1 check("async_reset_txd", {31'd0, txd}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus(32'h4, 32'h0, 4'h0, rd, lat);
    check("status_after_midreset", rd, 32'h0000_0004);
    repeat (60) @(negedge clk);
    check("no_resume", {31'd0, txd}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
